// File: rtl/in_spike_frame_buf_if.sv
// Router-side spike frame handshake: the router (master) offers a frame with valid,
// and the frame buffer (slave) answers with ready.
interface in_spike_frame_buf_if #(
    parameter int NUM_AXONS = 256
);
    logic [NUM_AXONS-1:0] spikeFrame_i;
    logic                 spikeFrameVld_i;
    logic                 spikeFrameRdy_o;

    modport master (
        output spikeFrame_i,
        output spikeFrameVld_i,
        input  spikeFrameRdy_o
    );

    modport slave (
        input  spikeFrame_i,
        input  spikeFrameVld_i,
        output spikeFrameRdy_o
    );
endinterface

// File: rtl/in_spike_frame_buf.sv
// Input spike frame buffer: a DEPTH-deep FIFO of spike vectors feeding a recall frame
// on each time-step start, with a learning snapshot and per-axon registered reads.
module in_spike_frame_buf #(
    parameter int NUM_AXONS          = 256,
    parameter int AXON_CNT_BIT_WIDTH = 8,
    parameter int DEPTH              = 4,
    parameter int DEPTH_BIT_WIDTH    = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    in_spike_frame_buf_if.slave           spk_if,
    input  logic                          start_i,
    input  logic [AXON_CNT_BIT_WIDTH-1:0] RclAxonAddr_i,
    input  logic                          rdEn_RclInSpike_i,
    input  logic                          saveRclSpikes_i,
    input  logic [AXON_CNT_BIT_WIDTH-1:0] LrnAxonAddr_i,
    input  logic                          rdEn_LrnInSpike_i,
    input  logic                          clrErr_i,
    output logic                          Rcl_InSpike_o,
    output logic                          Rcl_InSpikeVld_o,
    output logic                          Lrn_InSpike_o,
    output logic                          Lrn_InSpikeVld_o,
    output logic [DEPTH_BIT_WIDTH:0]      frameCnt_o,
    output logic                          underflow_o
);

    localparam logic [DEPTH_BIT_WIDTH:0] LP_FULL = (DEPTH_BIT_WIDTH+1)'(DEPTH);

    logic [NUM_AXONS-1:0]       r_fifo [DEPTH];
    logic [DEPTH_BIT_WIDTH-1:0] r_wrPtr;
    logic [DEPTH_BIT_WIDTH-1:0] r_rdPtr;
    logic [DEPTH_BIT_WIDTH:0]   r_cnt;
    logic [NUM_AXONS-1:0]       r_rcl;
    logic [NUM_AXONS-1:0]       r_lrn;
    logic                       r_rclBit;
    logic                       r_rclVld;
    logic                       r_lrnBit;
    logic                       r_lrnVld;
    logic                       r_underflow;

    logic w_rdy;
    logic w_push;
    logic w_pop;
    logic w_underflowEvt;
    logic w_rclBit;
    logic w_lrnBit;

    // Ready depends only on the registered count, so start_i cannot reach it.
    assign w_rdy          = (r_cnt != LP_FULL);
    assign w_push         = spk_if.spikeFrameVld_i & w_rdy;
    assign w_pop          = start_i & (r_cnt != '0);
    assign w_underflowEvt = start_i & (r_cnt == '0);

    // Out-of-range axon addresses read as silent axons.
    assign w_rclBit = (int'(RclAxonAddr_i) < NUM_AXONS) ? r_rcl[RclAxonAddr_i] : 1'b0;
    assign w_lrnBit = (int'(LrnAxonAddr_i) < NUM_AXONS) ? r_lrn[LrnAxonAddr_i] : 1'b0;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo[i] <= '0;
            end
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wrPtr] <= spk_if.spikeFrame_i;
                r_wrPtr         <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // An empty FIFO at time-step start yields a silent recall frame, not a stale one.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rcl       <= '0;
            r_lrn       <= '0;
            r_underflow <= 1'b0;
        end else begin
            if (start_i) begin
                r_rcl <= w_pop ? r_fifo[r_rdPtr] : '0;
            end
            if (saveRclSpikes_i) begin
                r_lrn <= r_rcl;
            end
            if (w_underflowEvt) begin
                r_underflow <= 1'b1;
            end else if (clrErr_i) begin
                r_underflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rclBit <= 1'b0;
            r_rclVld <= 1'b0;
            r_lrnBit <= 1'b0;
            r_lrnVld <= 1'b0;
        end else begin
            r_rclVld <= rdEn_RclInSpike_i;
            r_lrnVld <= rdEn_LrnInSpike_i;
            if (rdEn_RclInSpike_i) begin
                r_rclBit <= w_rclBit;
            end
            if (rdEn_LrnInSpike_i) begin
                r_lrnBit <= w_lrnBit;
            end
        end
    end

    assign spk_if.spikeFrameRdy_o = w_rdy;
    assign Rcl_InSpike_o          = r_rclBit;
    assign Rcl_InSpikeVld_o       = r_rclVld;
    assign Lrn_InSpike_o          = r_lrnBit;
    assign Lrn_InSpikeVld_o       = r_lrnVld;
    assign frameCnt_o             = r_cnt;
    assign underflow_o            = r_underflow;

endmodule

// File: tb/tb_in_spike_frame_buf.sv
// Directed bench for in_spike_frame_buf: a 256-axon instance for FIFO/recall/learn
// behaviour and a 200-axon instance for out-of-range address reads.
module tb_in_spike_frame_buf;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] rclAddr;
    logic       rdEnRcl;
    logic       saveRcl;
    logic [7:0] lrnAddr;
    logic       rdEnLrn;
    logic       clrErr;

    logic       rclBit0, rclVld0, lrnBit0, lrnVld0, underflow0;
    logic [2:0] frameCnt0;
    logic       rclBit1, rclVld1, lrnBit1, lrnVld1, underflow1;
    logic [2:0] frameCnt1;

    int checkCount;
    int errorCount;

    in_spike_frame_buf_if #(.NUM_AXONS(256)) spk0 ();
    in_spike_frame_buf_if #(.NUM_AXONS(200)) spk1 ();

    in_spike_frame_buf #(
        .NUM_AXONS(256), .AXON_CNT_BIT_WIDTH(8), .DEPTH(4), .DEPTH_BIT_WIDTH(2)
    ) dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .spk_if(spk0.slave), .start_i(start),
        .RclAxonAddr_i(rclAddr), .rdEn_RclInSpike_i(rdEnRcl), .saveRclSpikes_i(saveRcl),
        .LrnAxonAddr_i(lrnAddr), .rdEn_LrnInSpike_i(rdEnLrn), .clrErr_i(clrErr),
        .Rcl_InSpike_o(rclBit0), .Rcl_InSpikeVld_o(rclVld0),
        .Lrn_InSpike_o(lrnBit0), .Lrn_InSpikeVld_o(lrnVld0),
        .frameCnt_o(frameCnt0), .underflow_o(underflow0)
    );

    in_spike_frame_buf #(
        .NUM_AXONS(200), .AXON_CNT_BIT_WIDTH(8), .DEPTH(4), .DEPTH_BIT_WIDTH(2)
    ) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .spk_if(spk1.slave), .start_i(start),
        .RclAxonAddr_i(rclAddr), .rdEn_RclInSpike_i(rdEnRcl), .saveRclSpikes_i(saveRcl),
        .LrnAxonAddr_i(lrnAddr), .rdEn_LrnInSpike_i(rdEnLrn), .clrErr_i(clrErr),
        .Rcl_InSpike_o(rclBit1), .Rcl_InSpikeVld_o(rclVld1),
        .Lrn_InSpike_o(lrnBit1), .Lrn_InSpikeVld_o(lrnVld1),
        .frameCnt_o(frameCnt1), .underflow_o(underflow1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] frameBits(input int a, input int b);
        logic [255:0] f;
        f = '0;
        f[a] = 1'b1;
        if (b >= 0) f[b] = 1'b1;
        return f;
    endfunction

    // One clock of stimulus on the 256-axon instance, then controls return idle.
    task automatic applyStimulus(input logic vld, input logic [255:0] frame,
                                 input logic st, input logic sv, input logic clr);
        spk0.spikeFrameVld_i = vld;
        spk0.spikeFrame_i    = frame;
        start                = st;
        saveRcl              = sv;
        clrErr               = clr;
        step();
        spk0.spikeFrameVld_i = 1'b0;
        start                = 1'b0;
        saveRcl              = 1'b0;
        clrErr               = 1'b0;
    endtask

    task automatic readRcl(input string tag, input int addr, input logic expBit);
        rclAddr = 8'(addr);
        rdEnRcl = 1'b1;
        step();
        rdEnRcl = 1'b0;
        checkOutput({tag, "_bit"}, 32'(rclBit0), 32'(expBit));
        checkOutput({tag, "_vld"}, 32'(rclVld0), 32'd1);
    endtask

    task automatic readLrn(input string tag, input int addr, input logic expBit);
        lrnAddr = 8'(addr);
        rdEnLrn = 1'b1;
        step();
        rdEnLrn = 1'b0;
        checkOutput({tag, "_bit"}, 32'(lrnBit0), 32'(expBit));
        checkOutput({tag, "_vld"}, 32'(lrnVld0), 32'd1);
    endtask

    task automatic readRcl1(input string tag, input int addr, input logic expBit);
        rclAddr = 8'(addr);
        rdEnRcl = 1'b1;
        step();
        rdEnRcl = 1'b0;
        checkOutput({tag, "_bit"}, 32'(rclBit1), 32'(expBit));
        checkOutput({tag, "_vld"}, 32'(rclVld1), 32'd1);
    endtask

    initial begin
        logic [199:0] f200;
        checkCount = 0;
        errorCount = 0;
        rst_n = 1'b0;
        start = 1'b0; saveRcl = 1'b0; clrErr = 1'b0;
        rdEnRcl = 1'b0; rdEnLrn = 1'b0; rclAddr = '0; lrnAddr = '0;
        spk0.spikeFrameVld_i = 1'b0; spk0.spikeFrame_i = '0;
        spk1.spikeFrameVld_i = 1'b0; spk1.spikeFrame_i = '0;
        repeat (2) step();
        rst_n = 1'b1;
        step();

        $display("[TB] reset state");
        checkOutput("rst_cnt", 32'(frameCnt0), 32'd0);
        checkOutput("rst_rdy", 32'(spk0.spikeFrameRdy_o), 32'd1);
        checkOutput("rst_uflow", 32'(underflow0), 32'd0);
        checkOutput("rst_rclVld", 32'(rclVld0), 32'd0);

        $display("[TB] fill FIFO and drain in order");
        applyStimulus(1'b1, frameBits(0, -1), 1'b0, 1'b0, 1'b0);
        checkOutput("push_A_cnt", 32'(frameCnt0), 32'd1);
        applyStimulus(1'b1, frameBits(7, -1), 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, frameBits(20, 255), 1'b0, 1'b0, 1'b0);
        checkOutput("push_C_rdy", 32'(spk0.spikeFrameRdy_o), 32'd1);
        applyStimulus(1'b1, frameBits(100, -1), 1'b0, 1'b0, 1'b0);
        checkOutput("push_D_cnt", 32'(frameCnt0), 32'd4);
        checkOutput("full_rdy", 32'(spk0.spikeFrameRdy_o), 32'd0);
        applyStimulus(1'b1, frameBits(50, -1), 1'b0, 1'b0, 1'b0);
        checkOutput("push_E_cnt", 32'(frameCnt0), 32'd4);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        readRcl("popA_ax0", 0, 1'b1);
        checkOutput("popA_vldPulse", 32'(rclVld0), 32'd1);
        step();
        checkOutput("popA_vldLow", 32'(rclVld0), 32'd0);
        checkOutput("popA_bitHold", 32'(rclBit0), 32'd1);
        readRcl("popA_ax7", 7, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        readRcl("popB_ax7", 7, 1'b1);
        readRcl("popB_ax0", 0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        readRcl("popC_ax20", 20, 1'b1);
        readRcl("popC_ax255", 255, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        readRcl("popD_ax100", 100, 1'b1);
        readRcl("popD_ax50", 50, 1'b0);
        checkOutput("drain_cnt", 32'(frameCnt0), 32'd0);
        checkOutput("drain_uflow", 32'(underflow0), 32'd0);

        $display("[TB] underflow");
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checkOutput("uflow_set", 32'(underflow0), 32'd1);
        checkOutput("uflow_cnt", 32'(frameCnt0), 32'd0);
        readRcl("uflow_rclZero", 100, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("uflow_clr", 32'(underflow0), 32'd0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
        checkOutput("uflow_setWins", 32'(underflow0), 32'd1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("uflow_clr2", 32'(underflow0), 32'd0);

        $display("[TB] push+pop when full and pointer wrap");
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, frameBits(i, -1), 1'b0, 1'b0, 1'b0);
        end
        checkOutput("refill_cnt", 32'(frameCnt0), 32'd4);
        applyStimulus(1'b1, frameBits(9, -1), 1'b1, 1'b0, 1'b0);
        checkOutput("fullPP_cnt", 32'(frameCnt0), 32'd3);
        readRcl("fullPP_ax1", 1, 1'b1);
        applyStimulus(1'b1, frameBits(10, -1), 1'b1, 1'b0, 1'b0);
        checkOutput("pp_cnt", 32'(frameCnt0), 32'd3);
        readRcl("pp_ax2", 2, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        readRcl("wrap_ax3", 3, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        readRcl("wrap_ax4", 4, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        readRcl("wrap_ax10", 10, 1'b1);
        readRcl("wrap_ax9", 9, 1'b0);
        checkOutput("wrap_cnt", 32'(frameCnt0), 32'd0);
        checkOutput("wrap_uflow", 32'(underflow0), 32'd0);

        $display("[TB] save concurrent with start and read");
        applyStimulus(1'b1, frameBits(0, -1), 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, frameBits(7, -1), 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        rclAddr = 8'd0;
        rdEnRcl = 1'b1;
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
        rdEnRcl = 1'b0;
        checkOutput("concRd_bit", 32'(rclBit0), 32'd1);
        checkOutput("concRd_vld", 32'(rclVld0), 32'd1);
        step();
        checkOutput("concRd_vldLow", 32'(rclVld0), 32'd0);
        readLrn("save_lrnAx0", 0, 1'b1);
        step();
        checkOutput("save_lrnVldLow", 32'(lrnVld0), 32'd0);
        readLrn("save_lrnAx7", 7, 1'b0);
        readRcl("save_rclAx0", 0, 1'b0);
        readRcl("save_rclAx7", 7, 1'b1);

        $display("[TB] reset mid-traffic");
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, frameBits(5, -1), 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, frameBits(6, -1), 1'b0, 1'b0, 1'b0);
        checkOutput("pre_rst_cnt", 32'(frameCnt0), 32'd2);
        checkOutput("pre_rst_uflow", 32'(underflow0), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midRst_cnt", 32'(frameCnt0), 32'd0);
        checkOutput("midRst_rdy", 32'(spk0.spikeFrameRdy_o), 32'd1);
        checkOutput("midRst_uflow", 32'(underflow0), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        readRcl("midRst_rcl7", 7, 1'b0);
        readLrn("midRst_lrn0", 0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        readRcl("midRst_noFrame", 5, 1'b0);

        $display("[TB] 200-axon instance address range");
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        f200 = '0;
        f200[199] = 1'b1;
        f200[0]   = 1'b1;
        spk1.spikeFrame_i    = f200;
        spk1.spikeFrameVld_i = 1'b1;
        step();
        spk1.spikeFrameVld_i = 1'b0;
        checkOutput("n200_cnt", 32'(frameCnt1), 32'd1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        readRcl1("n200_ax199", 199, 1'b1);
        readRcl1("n200_ax250", 250, 1'b0);
        readRcl1("n200_ax198", 198, 1'b0);
        readRcl1("n200_ax0", 0, 1'b1);
        checkOutput("n200_uflow", 32'(underflow1), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
